lag_pl_tx: RTL and testbench



---
 rtl/lag_pl_tx_pkg.sv | 24 ++
 rtl/lag_pl_tx_credit_counter.sv | 70 +++++++
 rtl/lag_pl_tx.sv | 88 ++++++++
 tb/tb_lag_pl_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lag_pl_tx_pkg.sv
// ---------------------------------------------------------------------------
// lag_pl_tx_pkg
//   Shared types for the physical-lane (PL) link blocks.
//   - fifo_elements_t : one flit as stored in a PL FIFO entry
//   - fifov_flags_t   : per-FIFO status flags shared with the receive side
//   - credit_width()  : bits needed to hold a credit count of 0..depth
// ---------------------------------------------------------------------------
package lag_pl_tx_pkg;

  localparam int FLIT_W = 16;

  typedef logic [FLIT_W-1:0] fifo_elements_t;

  typedef struct packed {
    logic full;
    logic empty;
  } fifov_flags_t;

  // Credit counters must represent every value from 0 up to the FIFO depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lag_pl_tx_credit_counter.sv
// ---------------------------------------------------------------------------
// lag_pl_tx_credit_counter
//   Per-lane credit counter for the PL transmit side. Starts at `size`
//   (downstream FIFO depth), counts down on a send and up on a returned
//   credit. A credit returned while already at `size` saturates the count
//   and sets a sticky error flag that only reset clears.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   dec         a flit was sent on this lane this cycle
//   inc         downstream popped one flit from this lane this cycle
//   cnt         current credit count
//   nonzero     at least one credit available
//   at_max      count equals `size` (all credits home)
//   err         sticky: credit returned while already at `size`
// ---------------------------------------------------------------------------
module lag_pl_tx_credit_counter
  import lag_pl_tx_pkg::*;
#(
  parameter int size = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dec,
  input  logic                          inc,
  output logic [credit_width(size)-1:0] cnt,
  output logic                          nonzero,
  output logic                          at_max,
  output logic                          err
);

  localparam int            CW      = credit_width(size);
  localparam logic [CW-1:0] CNT_MAX = CW'(size);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          err_d, err_q;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({dec, inc})
      // dec is only ever asserted when the owner saw nonzero, so no underflow.
      2'b10: cnt_d = cnt_q - CW'(1);
      2'b01: begin
        if (cnt_q == CNT_MAX) err_d = 1'b1;
        else                  cnt_d = cnt_q + CW'(1);
      end
      default: ; // idle, or send and return in the same cycle: net zero
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);
  assign at_max  = (cnt_q == CNT_MAX);
  assign err     = err_q;

endmodule

// File: rtl/lag_pl_tx.sv
// ---------------------------------------------------------------------------
// lag_pl_tx
//   Transmit side of the credit-based physical-lane link. Each of the n lanes
//   owns a credit counter (initialised to the downstream FIFO depth `size`),
//   accepts a local flit whenever it holds a credit, and forwards it one
//   cycle later as a registered push into the matching downstream FIFO.
//   Lanes are fully independent.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    [n]   local flit offered on lane i
//   in_data     [n]   flit offered on lane i
//   in_ready    [n]   lane i has a credit (registered state only)
//   out_push    [n]   registered push to downstream FIFO[i]
//   out_data    [n]   registered flit to downstream FIFO[i]
//   credit_in   [n]   pulse: downstream FIFO[i] popped one flit
//   credits     CW*n  credit count per lane, lane i at [i*CW +: CW]
//   credit_err  [n]   sticky: credit returned while lane already full
//   idle        1     all credits home and no push in flight
// ---------------------------------------------------------------------------
module lag_pl_tx
  import lag_pl_tx_pkg::*;
#(
  parameter int size = 3,
  parameter int n    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic           [n-1:0]          in_valid,
  input  fifo_elements_t [n-1:0]          in_data,
  output logic           [n-1:0]          in_ready,
  output logic           [n-1:0]          out_push,
  output fifo_elements_t [n-1:0]          out_data,
  input  logic           [n-1:0]          credit_in,
  output logic [credit_width(size)*n-1:0] credits,
  output logic           [n-1:0]          credit_err,
  output logic                            idle
);

  localparam int CW = credit_width(size);

  logic [n-1:0] lane_full;

  for (genvar i = 0; i < n; i++) begin : pltx
    logic           xfer;
    logic [CW-1:0]  cnt;
    logic           nonzero;
    logic           push_d, push_q;
    fifo_elements_t data_d, data_q;

    // Ready depends only on the registered count, so a credit arriving while
    // empty is seen one cycle later, never combinationally.
    assign xfer = in_valid[i] & nonzero;

    lag_pl_tx_credit_counter #(.size(size)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .dec     (xfer),
      .inc     (credit_in[i]),
      .cnt     (cnt),
      .nonzero (nonzero),
      .at_max  (lane_full[i]),
      .err     (credit_err[i])
    );

    always_comb begin
      push_d = xfer;
      data_d = xfer ? in_data[i] : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        push_q <= 1'b0;
        data_q <= '0;
      end else begin
        push_q <= push_d;
        data_q <= data_d;
      end
    end

    assign in_ready[i]            = nonzero;
    assign out_push[i]            = push_q;
    assign out_data[i]            = data_q;
    assign credits[i*CW +: CW]    = cnt;
  end

  assign idle = (&lane_full) & ~(|out_push);

endmodule

// File: tb/tb_lag_pl_tx.sv
// ---------------------------------------------------------------------------
// tb_lag_pl_tx
//   Directed bench for lag_pl_tx with size=3, n=4. Inputs change 1 time unit
//   after a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_lag_pl_tx;
  import lag_pl_tx_pkg::*;

  localparam int SIZE = 3;
  localparam int N    = 4;
  localparam int CW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic           [N-1:0] in_valid;
  fifo_elements_t [N-1:0] in_data;
  logic           [N-1:0] in_ready;
  logic           [N-1:0] out_push;
  fifo_elements_t [N-1:0] out_data;
  logic           [N-1:0] credit_in;
  logic        [CW*N-1:0] credits;
  logic           [N-1:0] credit_err;
  logic                   idle;

  int n_checks = 0;
  int n_fail   = 0;

  lag_pl_tx #(.size(SIZE), .n(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_push   (out_push),
    .out_data   (out_data),
    .credit_in  (credit_in),
    .credits    (credits),
    .credit_err (credit_err),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cred(input int lane);
    return credits[lane*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] prev_push;

  initial begin
    in_valid  = '0;
    credit_in = '0;
    in_data   = '0;
    #12 rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_credits", credits, 32'hFF);
    check("rst_ready", in_ready, 32'hF);
    check("rst_idle", idle, 1);
    check("rst_push", out_push, 0);
    check("rst_err", credit_err, 0);
    check("rst_data", out_data, 0);

    // Lane 0: valid held 5 cycles, no credits returned
    in_valid[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_data[0] = 16'hA000 + 16'(k);
      tick();
      check("l0_push", out_push[0], (k <= 3) ? 1 : 0);
      check("l0_cred", cred(0), (k <= 3) ? 3 - k : 0);
      if (k <= 3) check("l0_data", out_data[0], 32'hA000 + k);
    end
    check("l0_data_hold", out_data[0], 32'hA003);
    check("l0_ready_empty", in_ready[0], 0);
    check("l0_not_idle", idle, 0);

    // Lane 0 empty: one credit back, ready next cycle, one push
    in_data[0]   = 16'hB000;
    credit_in[0] = 1'b1;
    tick();
    credit_in[0] = 1'b0;
    check("l0_ret_cred", cred(0), 1);
    check("l0_ret_ready", in_ready[0], 1);
    check("l0_ret_nopush", out_push[0], 0);
    tick();
    check("l0_ret_push", out_push[0], 1);
    check("l0_ret_data", out_data[0], 32'hB000);
    check("l0_ret_cred0", cred(0), 0);
    check("l0_ret_ready0", in_ready[0], 0);
    in_valid[0] = 1'b0;
    tick();
    check("l0_ret_push_end", out_push[0], 0);
    credit_in[0] = 1'b1;
    repeat (3) tick();
    credit_in[0] = 1'b0;
    check("l0_refill", cred(0), 3);
    check("l0_no_err", credit_err, 0);

    // Lane 1: send and credit return in the same cycle
    in_valid[1] = 1'b1;
    in_data[1]  = 16'hC001;
    tick();
    check("l1_cred2", cred(1), 2);
    check("l1_push_a", out_push[1], 1);
    in_data[1]   = 16'hC002;
    credit_in[1] = 1'b1;
    tick();
    in_valid[1]  = 1'b0;
    credit_in[1] = 1'b0;
    check("l1_same_cred", cred(1), 2);
    check("l1_same_push", out_push[1], 1);
    check("l1_same_data", out_data[1], 32'hC002);
    credit_in[1] = 1'b1;
    tick();
    credit_in[1] = 1'b0;
    check("l1_refill", cred(1), 3);
    check("l1_push_end", out_push[1], 0);
    check("l1_no_err", credit_err, 0);

    // Lane 2: credit returned at full -> saturate and sticky error
    credit_in[2] = 1'b1;
    tick();
    credit_in[2] = 1'b0;
    check("l2_sat_cred", cred(2), 3);
    check("l2_err", credit_err, 32'h4);
    check("l2_indep", credits, 32'hFF);
    in_valid[2] = 1'b1;
    in_data[2]  = 16'hD001;
    tick();
    in_valid[2]  = 1'b0;
    credit_in[2] = 1'b1;
    check("l2_send_cred", cred(2), 2);
    tick();
    credit_in[2] = 1'b0;
    check("l2_back_cred", cred(2), 3);
    check("l2_err_sticky", credit_err, 32'h4);
    check("idle_again", idle, 1);

    // All lanes streaming, credit returned two edges after each send
    prev_push = '0;
    in_valid  = '1;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) in_data[i] = 16'(i * 256 + k);
      tick();
      for (int i = 0; i < N; i++) begin
        check("stream_push", out_push[i], 1);
        check("stream_data", out_data[i], i * 256 + k);
        check("no_underflow", (cred(i) <= SIZE && cred(i) != 0) ? 1 : 0, 1);
      end
      credit_in = prev_push;
      prev_push = out_push;
    end
    check("stream_err_sticky", credit_err, 32'h4);
    check("stream_not_idle", idle, 0);

    // Asynchronous reset mid-stream
    #3 rst_n = 1'b0;
    #1;
    check("arst_push", out_push, 0);
    check("arst_credits", credits, 32'hFF);
    check("arst_err", credit_err, 0);
    check("arst_idle", idle, 1);
    check("arst_data", out_data, 0);
    in_valid  = '0;
    credit_in = '0;
    #20 rst_n = 1'b1;
    tick();
    check("post_rst_idle", idle, 1);
    check("post_rst_ready", in_ready, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
